// File: rtl/alu_div_pkg.sv
// Shared ALU divider definitions: FSM state encoding, default operand width
// and the saturated quotient returned on divide-by-zero or overflow.
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH = 16;

  localparam logic [DIV_WIDTH-1:0] QUOT_SAT = '1;

endpackage

// File: rtl/divider_32x16_seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, report the quotient bit.
// The stored partial remainder is always below the divisor, so it fits WIDTH
// bits; only the shifted intermediate needs the extra bit.
module div_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] pr,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] pr_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;

  // Compare/subtract on the shifted partial remainder.
  always_comb begin
    shifted = {pr, din};
    qbit    = (shifted >= {1'b0, divisor});
    pr_next = qbit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_32x16_seq.sv
// Sequential restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock. Divide-by-zero and quotient overflow are caught
// at accept time and finish in a single cycle.
// Optional feature macro: DIV_SIGNED_EN adds a signed_op input; signed
// operands are divided as magnitudes and a FIXUP cycle restores the signs
// (truncating division, remainder takes the dividend sign).
module divider_32x16_seq
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
`ifdef DIV_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH);
  // Saturated quotient, all ones at any WIDTH.
  localparam logic [WIDTH-1:0] SAT = {WIDTH{QUOT_SAT[0]}};

  div_state_e         state_q, state_d;
  logic [WIDTH-1:0]   pr_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   sh_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [CW-1:0]      cnt_q;
  logic               dbz_q, ovf_q;

  logic [2*WIDTH-1:0] mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               ovf_in;
  logic               accept;
  logic [WIDTH-1:0]   step_pr;
  logic               step_q;

`ifdef DIV_SIGNED_EN
  logic               neg_a, neg_b;
  logic               sgn_q, nq_q, nr_q;
  logic [WIDTH-1:0]   fix_q, fix_r;
  logic               fix_ovf;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  // A negative result may reach -2^(W-1); a positive one only 2^(W-1)-1.
  function automatic logic quot_oflow(input logic [WIDTH-1:0] qm, input logic neg);
    return neg ? (qm > {1'b1, {(WIDTH-1){1'b0}}}) : qm[WIDTH-1];
  endfunction

  // Reduce signed operands to magnitudes before the unsigned iteration.
  always_comb begin
    neg_a = signed_op & dividend[2*WIDTH-1];
    neg_b = signed_op & divisor[WIDTH-1];
    mag_a = neg_a ? neg_dw(dividend) : dividend;
    mag_b = neg_b ? neg_w(divisor) : divisor;
  end

  // Sign restoration and range check applied in the FIXUP cycle.
  always_comb begin
    fix_ovf = quot_oflow(quot_q, nq_q);
    fix_q   = nq_q ? neg_w(quot_q) : quot_q;
    fix_r   = nr_q ? neg_w(pr_q) : pr_q;
  end
`else
  assign mag_a = dividend;
  assign mag_b = divisor;
`endif

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign ovf_in = (mag_a[2*WIDTH-1:WIDTH] >= mag_b);

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr_q),
    .din     (sh_q[WIDTH-1]),
    .divisor (dvs_q),
    .pr_next (step_pr),
    .qbit    (step_q)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if ((divisor == '0) || ovf_in) state_d = DONE;
          else                           state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
          state_d = sgn_q ? FIXUP : DONE;
`else
          state_d = DONE;
`endif
        end
      end
      FIXUP:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State, result registers and flags; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pr_q    <= '0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            if (divisor == '0) begin
              dbz_q  <= 1'b1;
              quot_q <= SAT;
              pr_q   <= dividend[WIDTH-1:0];
            end else if (ovf_in) begin
              ovf_q  <= 1'b1;
              quot_q <= SAT;
              pr_q   <= '0;
            end else begin
              quot_q <= '0;
              pr_q   <= mag_a[2*WIDTH-1:WIDTH];
            end
          end
        end
        RUN: begin
          pr_q   <= step_pr;
          quot_q <= {quot_q[WIDTH-2:0], step_q};
        end
`ifdef DIV_SIGNED_EN
        FIXUP: begin
          if (fix_ovf) begin
            ovf_q  <= 1'b1;
            quot_q <= SAT;
            pr_q   <= '0;
          end else begin
            quot_q <= fix_q;
            pr_q   <= fix_r;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Operand shift register, divisor and iteration counter; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_q  <= mag_a[WIDTH-1:0];
      dvs_q <= mag_b;
      cnt_q <= CW'(WIDTH-1);
`ifdef DIV_SIGNED_EN
      sgn_q <= signed_op;
      nq_q  <= neg_a ^ neg_b;
      nr_q  <= neg_a;
`endif
    end else if (state_q == RUN) begin
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = pr_q;
  assign busy        = (state_q == RUN) || (state_q == FIXUP);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_32x16_seq.sv
// Scoreboard bench for divider_32x16_seq: the driver pushes hand-computed
// results, a negedge monitor pops and compares when a result is presented.
module tb_divider_32x16_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient, remainder;
  logic        busy, done, div_by_zero, overflow;
`ifdef DIV_SIGNED_EN
  logic        signed_op;
`endif

  always #5 clk = ~clk;

  divider_32x16_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          bsy;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pcyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) pcyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: result presented when done is high with an accepted op queued.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (reset) busy_cnt = 0;
    if (done && (sb.size() > 0)) begin
      mon_e = sb.pop_front();
      chk("quotient",    {16'h0, quotient},  {16'h0, mon_e.q});
      chk("remainder",   {16'h0, remainder}, {16'h0, mon_e.r});
      chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, mon_e.dbz});
      chk("overflow",    {31'h0, overflow},  {31'h0, mon_e.ovf});
      chk("latency",     pcyc - mon_e.acc + 1, mon_e.lat);
      chk("busy_cycles", busy_cnt, mon_e.bsy);
      chk("busy_and_done", {31'h0, busy & done}, 32'h0);
      busy_cnt = 0;
    end
  end

  // Present operands so they are sampled at the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edbz, input logic eovf,
                       input int elat, input int ebsy);
    exp_t e;
    #1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    e = '{eq, er, edbz, eovf, elat, ebsy, pcyc};
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: done not seen within 64 cycles");
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_quotient",  {16'h0, quotient}, 32'h0);
    chk("rst_remainder", {16'h0, remainder}, 32'h0);
    chk("rst_busy",      {31'h0, busy}, 32'h0);
    chk("rst_done",      {31'h0, done}, 32'h0);
    chk("rst_dbz",       {31'h0, div_by_zero}, 32'h0);
    chk("rst_ovf",       {31'h0, overflow}, 32'h0);
    #1 reset = 1'b0;

    // Normal divides
    @(negedge clk); issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17, 16);
    wait_done();
    @(negedge clk); issue(32'h0001_0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 1'b0, 17, 16);
    wait_done();
    @(negedge clk); issue(32'h0000_FFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 17, 16);
    wait_done();
    @(negedge clk); issue(32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 16);
    wait_done();
    @(negedge clk); issue(32'd5, 16'd7, 16'd0, 16'd5, 1'b0, 1'b0, 17, 16);
    wait_done();

    // Divide by zero and overflow finish in one cycle
    @(negedge clk); issue(32'h1234_5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 1, 0);
    wait_done();
    @(negedge clk); issue(32'h0002_0000, 16'h0002, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1, 0);
    wait_done();

    // Start during RUN is ignored
    @(negedge clk); issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17, 16);
    repeat (4) @(negedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'h1234_5678;
    divisor  = 16'h0000;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // Back-to-back: next start on the first done cycle
    @(negedge clk); issue(32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b0, 17, 16);
    wait_done();
    issue(32'h0001_2345, 16'h0100, 16'h0123, 16'h0045, 1'b0, 1'b0, 17, 16);
    wait_done();

    // Reset in the middle of RUN
    @(negedge clk); issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17, 16);
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    chk("midrst_quotient",  {16'h0, quotient}, 32'h0);
    chk("midrst_remainder", {16'h0, remainder}, 32'h0);
    chk("midrst_busy",      {31'h0, busy}, 32'h0);
    chk("midrst_done",      {31'h0, done}, 32'h0);
    chk("midrst_dbz",       {31'h0, div_by_zero}, 32'h0);
    chk("midrst_ovf",       {31'h0, overflow}, 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); issue(32'd50000, 16'd3, 16'd16666, 16'd2, 1'b0, 1'b0, 17, 16);
    wait_done();

`ifdef DIV_SIGNED_EN
    // Signed: -100 / 7 and a positive quotient out of range
    @(negedge clk);
    signed_op = 1'b1;
    issue(32'hFFFF_FF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18, 17);
    wait_done();
    @(negedge clk);
    issue(32'h0000_8000, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 18, 17);
    wait_done();
    signed_op = 1'b0;
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
